// File: rtl/regfile_exec_pkg.sv
// Shared opcode/state types and helpers for the regfile_exec execution unit.
package regfile_exec_pkg;

   typedef enum logic [2:0] {
      OP_WR   = 3'b000,
      OP_RD1  = 3'b001,
      OP_RD2  = 3'b010,
      OP_RDWR = 3'b011,
      OP_ADD  = 3'b100,
      OP_SUB  = 3'b101,
      OP_SHL  = 3'b110,
      OP_SRA  = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_e;

   function automatic logic is_alu(input op_e op);
      return op inside {OP_ADD, OP_SUB, OP_SHL, OP_SRA};
   endfunction

endpackage

// File: rtl/regfile_exec_if.sv
// Instruction/handshake bundle between an issuing master and the regfile_exec unit.
interface regfile_exec_if #(
   parameter int DW  = 16,
   parameter int AW  = 5,
   parameter int SHW = 4
) ();
   import regfile_exec_pkg::*;

   logic           start;
   logic           ready;
   op_e            op;
   logic [AW-1:0]  ra1;
   logic [AW-1:0]  ra2;
   logic [AW-1:0]  wa;
   logic [DW-1:0]  wdata;
   logic [SHW-1:0] shamt;
   logic [DW-1:0]  rd1;
   logic [DW-1:0]  rd2;
   logic [DW-1:0]  result;
   logic           ovf;
   logic           done;

   modport master (
      output start, op, ra1, ra2, wa, wdata, shamt,
      input  ready, rd1, rd2, result, ovf, done
   );

   modport slave (
      input  start, op, ra1, ra2, wa, wdata, shamt,
      output ready, rd1, rd2, result, ovf, done
   );

endinterface

// File: rtl/regfile_exec_alu.sv
// Combinational ALU: wrap-around add/sub with signed overflow, logical left and arithmetic right shift.
module regfile_exec_alu
   import regfile_exec_pkg::*;
#(
   parameter int DW  = 16,
   parameter int SHW = $clog2(DW)
) (
   input  op_e            op,
   input  logic [DW-1:0]  a,
   input  logic [DW-1:0]  b,
   input  logic [SHW-1:0] shamt,
   output logic [DW-1:0]  y,
   output logic           ovf
);

   always_comb begin
      // NOTE: defaults first so every path assigns y and ovf; a missing branch would infer a latch.
      y   = '0;
      ovf = 1'b0;
      case (op)
         OP_ADD: begin
            y   = a + b;
            ovf = (a[DW-1] == b[DW-1]) && (y[DW-1] != a[DW-1]);
         end
         OP_SUB: begin
            y   = a - b;
            ovf = (a[DW-1] != b[DW-1]) && (y[DW-1] != a[DW-1]);
         end
         OP_SHL:  y = a << shamt;
         OP_SRA:  y = $signed(a) >>> shamt;
         default: ;
      endcase
   end

endmodule

// File: rtl/regfile_exec.sv
// Multi-cycle register-file execution unit: READ -> (EXEC) -> WB phases with configurable latencies.
module regfile_exec
   import regfile_exec_pkg::*;
#(
   parameter int DW       = 16,
   parameter int NREG     = 32,
   parameter int AW       = $clog2(NREG),
   parameter int SHW      = $clog2(DW),
   parameter int READ_LAT = 2,
   parameter int EXEC_LAT = 16,
   parameter int WB_LAT   = 2
) (
   input logic           clk,
   input logic           rst_n,
   regfile_exec_if.slave bus
);

   localparam int MAX_LAT = (READ_LAT > EXEC_LAT) ?
                            ((READ_LAT > WB_LAT) ? READ_LAT : WB_LAT) :
                            ((EXEC_LAT > WB_LAT) ? EXEC_LAT : WB_LAT);
   localparam int CW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

   state_e          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic            phase_end;
   logic            accept;
   logic            finish;

   logic [DW-1:0]   regs [NREG];
   op_e             op_q;
   logic [AW-1:0]   ra1_q, ra2_q, wa_q;
   logic [DW-1:0]   wdata_q;
   logic [SHW-1:0]  shamt_q;
   logic [DW-1:0]   opa, opb, alu_y, alu_q;
   logic            alu_ovf, alu_ovf_q;
   logic [DW-1:0]   rd1_q, rd2_q, result_q;
   logic            ovf_q, done_q;

   assign accept = (state == IDLE) && bus.start;
   assign finish = phase_end && (state_nxt == IDLE);

   always_comb begin
      state_nxt = state;
      phase_end = 1'b0;
      unique case (state)
         IDLE: if (bus.start) state_nxt = READ;
         READ: begin
            phase_end = (cnt == CW'(READ_LAT - 1));
            if (phase_end) begin
               if (is_alu(op_q))          state_nxt = EXEC;
               else if (op_q == OP_RDWR)  state_nxt = WB;
               else                       state_nxt = IDLE;
            end
         end
         EXEC: begin
            phase_end = (cnt == CW'(EXEC_LAT - 1));
            if (phase_end) state_nxt = WB;
         end
         WB: begin
            phase_end = (cnt == CW'(WB_LAT - 1));
            if (phase_end) state_nxt = IDLE;
         end
      endcase
   end

   // Counter restarts on every phase change so each phase counts from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
         state <= state_nxt;
         cnt   <= (state_nxt != state) ? '0 : cnt + 1'b1;
      end
   end

   regfile_exec_alu #(.DW(DW), .SHW(SHW)) u_alu (
      .op    (op_q),
      .a     (opa),
      .b     (opb),
      .shamt (shamt_q),
      .y     (alu_y),
      .ovf   (alu_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the array is built from flops, not RAM, because reset must clear every register.
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         op_q      <= OP_WR;
         ra1_q     <= '0;
         ra2_q     <= '0;
         wa_q      <= '0;
         wdata_q   <= '0;
         shamt_q   <= '0;
         opa       <= '0;
         opb       <= '0;
         alu_q     <= '0;
         alu_ovf_q <= 1'b0;
         rd1_q     <= '0;
         rd2_q     <= '0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= finish;
         if (accept) begin
            op_q    <= bus.op;
            ra1_q   <= bus.ra1;
            ra2_q   <= bus.ra2;
            wa_q    <= bus.wa;
            wdata_q <= bus.wdata;
            shamt_q <= bus.shamt;
         end
         if (state == READ && phase_end) begin
            unique case (op_q)
               OP_WR:   regs[wa_q] <= wdata_q;
               OP_RD1,
               OP_RDWR: rd1_q <= regs[ra1_q];
               OP_RD2: begin
                  rd1_q <= regs[ra1_q];
                  rd2_q <= regs[ra2_q];
               end
               OP_ADD, OP_SUB, OP_SHL, OP_SRA: begin
                  opa <= regs[ra1_q];
                  opb <= regs[ra2_q];
               end
            endcase
         end
         if (state == EXEC && phase_end) begin
            alu_q     <= alu_y;
            alu_ovf_q <= alu_ovf;
         end
         if (state == WB && phase_end) begin
            if (is_alu(op_q)) begin
               regs[wa_q] <= alu_q;
               result_q   <= alu_q;
               ovf_q      <= alu_ovf_q;
            end else begin
               regs[wa_q] <= wdata_q;
            end
         end
      end
   end

   assign bus.ready  = (state == IDLE);
   assign bus.rd1    = rd1_q;
   assign bus.rd2    = rd2_q;
   assign bus.result = result_q;
   assign bus.ovf    = ovf_q;
   assign bus.done   = done_q;

endmodule
